// File: rtl/inverter_pkg.sv
// Shared display constants for the switch-inverter board demo.
// Segment patterns are active-low {g,f,e,d,c,b,a}. Anode patterns are active-low.
package inverter_pkg;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_DIGIT0 = 4'b1110;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Width of the debounce counter. It covers DEBOUNCE_CYCLES up to 2^16-1.
   localparam int unsigned CNT_W = 16;

   function automatic logic [6:0] seg_bit(input logic b);
      return b ? SEG_ONE : SEG_ZERO;
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a saturating debounce counter.
// dout only follows din after the synchronised level has held for DEBOUNCE_CYCLES cycles.
module switch_debounce
   import inverter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_pipe;
   logic [CNT_W-1:0] cnt;
   logic             stable;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_pipe <= '0;
         cnt       <= '0;
         stable    <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[0], din};
         if (sync_pipe[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
            stable <= sync_pipe[1];
            cnt    <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign dout = stable;

endmodule

// File: rtl/inverter.sv
// Board demo top: debounced sw0 is inverted and shown as '0' or '1' on the rightmost
// digit of a common-anode 7-segment display. All outputs are registered.
module inverter
   import inverter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw0,
   output logic [6:0] seg,
   output logic [3:0] an
);

   logic stable;
   logic inv;

   switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk (clk),
      .rst (rst),
      .din (sw0),
      .dout(stable)
   );

   assign inv = ~stable;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_BLANK;
         an  <= AN_OFF;
      end else begin
         seg <= seg_bit(inv);
         an  <= AN_DIGIT0;
      end
   end

endmodule

// File: tb/tb_inverter.sv
// Directed bench for inverter: reset, steady level, exact 7-cycle latency,
// alternation, glitch rejection and reset in the middle of a debounce.
module tb_inverter;

   localparam logic [6:0] S_ZERO  = 7'b1000000;
   localparam logic [6:0] S_ONE   = 7'b1111001;
   localparam logic [6:0] S_BLANK = 7'h7F;
   localparam logic [3:0] A_DIG0  = 4'b1110;
   localparam logic [3:0] A_OFF   = 4'hF;

   logic       clk;
   logic       rst;
   logic       sw0;
   logic [6:0] seg;
   logic [3:0] an;

   int n_tests;
   int n_fail;

   inverter #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk),
      .rst(rst),
      .sw0(sw0),
      .seg(seg),
      .an (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a new sw0 level and watch 10 cycles (100 ns). seg must keep old_seg for
   // six edges and show new_seg from the 7th edge on; an stays on digit 0.
   task automatic apply_level(input string tag, input logic lvl,
                              input logic [6:0] old_seg, input logic [6:0] new_seg);
      sw0 = lvl;
      for (int c = 1; c <= 10; c++) begin
         step();
         chk($sformatf("%s_seg_c%0d", tag, c), 32'(seg), (c < 7) ? 32'(old_seg) : 32'(new_seg));
         chk($sformatf("%s_an_c%0d", tag, c), 32'(an), 32'(A_DIG0));
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      sw0 = 1'b0;

      // Reset held for 3 cycles: display blank.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_seg", 32'(seg), 32'(S_BLANK));
         chk("rst_an", 32'(an), 32'(A_OFF));
      end

      // Release with sw0=0: '1' from the next cycle, held steady for 100 ns.
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("steady0_seg", 32'(seg), 32'(S_ONE));
         chk("steady0_an", 32'(an), 32'(A_DIG0));
      end

      // 0->1 edge: '0' exactly 7 cycles later, then held.
      apply_level("rise", 1'b1, S_ONE, S_ZERO);

      // Alternate every 100 ns.
      apply_level("alt0", 1'b0, S_ZERO, S_ONE);
      apply_level("alt1", 1'b1, S_ONE, S_ZERO);
      apply_level("alt2", 1'b0, S_ZERO, S_ONE);
      apply_level("alt3", 1'b1, S_ONE, S_ZERO);

      // Return to stable=0, then a 2-cycle high glitch must be discarded.
      apply_level("pre_glitch", 1'b0, S_ZERO, S_ONE);
      sw0 = 1'b1;
      step();
      step();
      sw0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("glitch_seg", 32'(seg), 32'(S_ONE));
      end

      // Reset 2 cycles after a sw0 change discards the pending debounce.
      sw0 = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      chk("midrst_seg", 32'(seg), 32'(S_BLANK));
      chk("midrst_an", 32'(an), 32'(A_OFF));
      step();
      chk("midrst_seg2", 32'(seg), 32'(S_BLANK));
      rst = 1'b0;
      // sw0 is still 1 but must pass sync + debounce again from scratch.
      for (int c = 1; c <= 10; c++) begin
         step();
         chk($sformatf("postrst_seg_c%0d", c), 32'(seg), (c < 7) ? 32'(S_ONE) : 32'(S_ZERO));
         chk("postrst_an", 32'(an), 32'(A_DIG0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
